pll_lock_sequencer: RTL and testbench

Supervises the rPLL that generates the 25.2 MHz pixel clock. It pulses the PLL reset, waits for LOCK, and requires LOCK to hold for a stabilisation window. Only then does it enable the gated pixel clock and release the downstream video-domain reset. It retries on lock timeout or lock loss, and latches a fault after too many failed attempts. It runs on the 27 MHz board oscillator, upstream of the VGA timing logic.

---
 rtl/pll_lock_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up the pixel-clock rPLL and guards the video domain.
// Pulses PLL reset, waits for a synchronised LOCK, requires it to stay up for a
// stabilisation window, then enables the pixel clock gate and releases video reset.
// Failed attempts (lock timeout, glitch while stabilising, lock loss in RUN) are
// retried up to MAX_RETRIES times before the block parks in FAULT.
//
// Ports:
//   in_clk      in   27 MHz reference clock (only clock)
//   rst         in   asynchronous active-high reset (sync-released internally)
//   pll_lock    in   rPLL LOCK, asynchronous to in_clk
//   restart     in   synchronous re-run request, also clears FAULT
//   pll_reset   out  rPLL RESET
//   clk_en      out  pixel clock gate qualifier
//   video_rst   out  active-high pixel-domain reset
//   ready       out  high in RUN
//   fault       out  high in FAULT
//   retry_count out  failed attempts since rst/restart, saturating at 3
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic       in_clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       clk_en,
  output logic       video_rst,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABILIZE = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  // Reset: asserted asynchronously, released synchronously through two flops.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  // LOCK synchroniser; every decision below uses lock_s_q only.
  logic lock_meta_q;
  logic lock_s_q;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             fail;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TO_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the last timeout cycle still wins.
        if (lock_s_q) begin
          state_d = S_STABILIZE;
          cnt_d   = STB_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STABILIZE: begin
        // Lock dropping on the last stabilise cycle is still a failure.
        if (!lock_s_q) begin
          fail = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          fail = 1'b1;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = RST_LOAD;
      end
    endcase

    // Retry decision is made on the count before this failure is added.
    if (fail) begin
      if (retry_q != 2'd3) begin
        retry_d = retry_q + 2'd1;
      end
      if (int'(retry_q) < MAX_RETRIES) begin
        state_d = S_PLL_RST;
        cnt_d   = RST_LOAD;
      end else begin
        state_d = S_FAULT;
      end
    end

    if (restart) begin
      state_d = S_PLL_RST;
      cnt_d   = RST_LOAD;
      retry_d = 2'd0;
    end
  end

  logic pll_reset_q, clk_en_q, video_rst_q, ready_q, fault_q;

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and never glitch.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= RST_LOAD;
      retry_q     <= 2'd0;
      pll_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else if (rst_sync_q) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= RST_LOAD;
      retry_q     <= 2'd0;
      pll_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      video_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      clk_en_q    <= (state_d == S_RUN);
      video_rst_q <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign clk_en      = clk_en_q;
  assign video_rst   = video_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  logic       in_clk;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       pll_reset;
  logic       clk_en;
  logic       video_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;

  int tests = 0;
  int fails = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR),
    .CNT_W        (8)
  ) dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .restart    (restart),
    .pll_reset  (pll_reset),
    .clk_en     (clk_en),
    .video_rst  (video_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge in_clk);
  endtask

  // Output invariants, sampled away from the active edge.
  always @(negedge in_clk) begin
    chk("inv_rst_and_clken", {31'b0, pll_reset & clk_en}, 0);
    chk("inv_clken_no_ready", {31'b0, clk_en & ~ready}, 0);
    chk("inv_video_rst", {31'b0, ~clk_en & ~video_rst}, 0);
  end

  task automatic wait_pll_reset_low(input string tag);
    int n = 0;
    while (pll_reset && n < 100) begin
      step();
      n++;
    end
    chk(tag, {31'b0, pll_reset}, 0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    chk(tag, {31'b0, ready}, 1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    int k;
    int width;
    int pulses;
    int fault_at;
    int idx;
    logic prev;
    logic [1:0] last_retry;
    logic [1:0] seq[4];
    logic ready_seen;

    rst = 1'b1;
    pll_lock = 1'b0;
    restart = 1'b0;
    repeat (3) step();

    // Reset values while rst is held.
    chk("rst_pll_reset", {31'b0, pll_reset}, 1);
    chk("rst_clk_en", {31'b0, clk_en}, 0);
    chk("rst_video_rst", {31'b0, video_rst}, 1);
    chk("rst_ready", {31'b0, ready}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_retry", {30'b0, retry_count}, 0);

    rst = 1'b0;
    step();
    chk("rel1_pll_reset", {31'b0, pll_reset}, 1);
    chk("rel1_video_rst", {31'b0, video_rst}, 1);

    // ---- Nominal bring-up ----
    wait_pll_reset_low("nom_leave_pll_rst");
    pulse_restart();
    width = 0;
    while (pll_reset && width < 50) begin
      width++;
      step();
    end
    chk("nom_pll_reset_width", width, RC);
    repeat (10) step();
    pll_lock = 1'b1;
    k = 0;
    while (!ready && k < 50) begin
      step();
      k++;
    end
    // Nominal: 2 sync + 1 WAIT_LOCK exit + SC stabilise cycles.
    chk("nom_ready_latency", {31'b0, (k >= SC + 2) && (k <= SC + 4)}, 1);
    chk("nom_clk_en", {31'b0, clk_en}, 1);
    chk("nom_video_rst", {31'b0, video_rst}, 0);
    chk("nom_pll_reset", {31'b0, pll_reset}, 0);
    chk("nom_retry", {30'b0, retry_count}, 0);

    // ---- Glitch while stabilising ----
    pll_lock = 1'b0;
    pulse_restart();
    wait_pll_reset_low("gl_leave_pll_rst");
    pll_lock = 1'b1;
    repeat (5) step();          // stabilise counter now at 5
    pll_lock = 1'b0;
    ready_seen = ready;
    repeat (3) begin
      step();
      ready_seen = ready_seen | ready;
    end
    pll_lock = 1'b1;
    chk("gl_ready_never", {31'b0, ready_seen}, 0);
    chk("gl_pll_reset", {31'b0, pll_reset}, 1);
    chk("gl_retry", {30'b0, retry_count}, 1);
    wait_ready("gl_recover_ready");
    chk("gl_recover_retry", {30'b0, retry_count}, 1);

    // ---- Lock loss in RUN ----
    pulse_restart();
    chk("ll_restart_retry", {30'b0, retry_count}, 0);
    wait_ready("ll_ready");
    pll_lock = 1'b0;
    repeat (3) step();
    chk("ll_clk_en", {31'b0, clk_en}, 0);
    chk("ll_video_rst", {31'b0, video_rst}, 1);
    chk("ll_ready", {31'b0, ready}, 0);
    chk("ll_pll_reset", {31'b0, pll_reset}, 1);
    chk("ll_retry", {30'b0, retry_count}, 1);
    pll_lock = 1'b1;
    wait_ready("ll_recover_ready");
    chk("ll_recover_retry", {30'b0, retry_count}, 1);
    chk("ll_recover_clk_en", {31'b0, clk_en}, 1);

    // Second loss, then hold in STABILIZE for the async reset check.
    pll_lock = 1'b0;
    repeat (3) step();
    chk("ll2_retry", {30'b0, retry_count}, 2);
    pll_lock = 1'b1;
    wait_pll_reset_low("ar_leave_pll_rst");
    repeat (3) step();
    chk("ar_pre_ready", {31'b0, ready}, 0);
    chk("ar_pre_pll_reset", {31'b0, pll_reset}, 0);

    // ---- Asynchronous reset between edges ----
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pll_reset", {31'b0, pll_reset}, 1);
    chk("ar_clk_en", {31'b0, clk_en}, 0);
    chk("ar_video_rst", {31'b0, video_rst}, 1);
    chk("ar_ready", {31'b0, ready}, 0);
    chk("ar_fault", {31'b0, fault}, 0);
    chk("ar_retry", {30'b0, retry_count}, 0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("ar_rel_pll_reset", {31'b0, pll_reset}, 1);
    wait_pll_reset_low("ar_rel_leave_pll_rst");
    wait_ready("ar_rel_ready");
    chk("ar_rel_retry", {30'b0, retry_count}, 0);

    // ---- Lock timeout to FAULT ----
    pll_lock = 1'b0;
    pulse_restart();
    prev = 1'b0;
    pulses = 0;
    fault_at = 0;
    idx = 0;
    last_retry = 2'd0;
    for (int n = 1; n <= 200; n++) begin
      if (retry_count != last_retry) begin
        if (idx < 4) seq[idx] = retry_count;
        idx++;
        last_retry = retry_count;
      end
      if (fault) begin
        fault_at = n;
        break;
      end
      if (pll_reset && !prev) pulses++;
      prev = pll_reset;
      step();
    end
    // Each attempt is RC reset cycles + LT wait cycles.
    chk("to_fault_at", fault_at, 3 * (RC + LT) + 1);
    chk("to_pulses", pulses, 3);
    chk("to_retry_steps", idx, 3);
    chk("to_retry_seq0", {30'b0, seq[0]}, 1);
    chk("to_retry_seq1", {30'b0, seq[1]}, 2);
    chk("to_retry_seq2", {30'b0, seq[2]}, 3);
    chk("to_fault_pll_reset", {31'b0, pll_reset}, 1);
    repeat (5) step();
    chk("to_fault_hold", {31'b0, fault}, 1);
    chk("to_fault_hold_pll_reset", {31'b0, pll_reset}, 1);

    pulse_restart();
    chk("to_restart_fault", {31'b0, fault}, 0);
    chk("to_restart_retry", {30'b0, retry_count}, 0);
    width = 0;
    while (pll_reset && width < 50) begin
      width++;
      step();
    end
    chk("to_restart_width", width, RC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
